window_buffer_5x5_ctrl: RTL and testbench

Sequencing controller for the 5x5 window buffer datapath. Accepts a frame start command and a column-valid stream from the line buffers, and drives the datapath count enable. It tracks input column and row-group position and tags every cycle on which the 25 window outputs hold a complete, frame-interior 5x5 neighbourhood. It sits between the line-buffer stage and the 5x5 filter kernels, and also reports frame completion and stream errors.

---
 rtl/window_buffer_5x5_ctrl.sv | 141 ++++++++++++++
 tb/tb_window_buffer_5x5_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/window_buffer_5x5_ctrl.sv
// window_buffer_5x5_ctrl
//   Sequencing controller for the 5x5 window buffer datapath. Accepts a frame
//   start command and a column-valid stream from the line buffers, drives the
//   datapath count enable, and tags every cycle on which the window outputs
//   hold a complete frame-interior 5x5 neighbourhood.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous reset, active HIGH despite the name
//   start_i      one-cycle frame start command
//   valid_i      one 5-row column present on the datapath inputs
//   ready_o      controller is accepting columns
//   count_en_o   column accepted this cycle (datapath count_en)
//   win_valid_o  window outputs hold a complete 5x5 window
//   win_col_o    output column of the current window, 0..COLS-5
//   win_row_o    output row of the current window, 0..ROWS-5
//   busy_o       frame in progress
//   frame_done_o one-cycle pulse with the last window of the frame
//   err_o        sticky mid-row gap error, cleared by the next start
module window_buffer_5x5_ctrl #(
    parameter int COLS = 640,
    parameter int ROWS = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       count_en_o,
    output logic       win_valid_o,
    output logic [9:0] win_col_o,
    output logic [9:0] win_row_o,
    output logic       busy_o,
    output logic       frame_done_o,
    output logic       err_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam logic [9:0] COL_LAST = 10'(COLS - 1);
    localparam logic [9:0] ROW_LAST = 10'(ROWS - 5);

    state_t     state;
    logic [9:0] col;
    logic [9:0] row;
    logic       drain_cnt;

    // First tag stage, aligned with the datapath delay register.
    logic       s1_valid;
    logic       s1_last;
    logic [9:0] s1_col;
    logic [9:0] s1_row;

    logic accept;
    logic last_col;

    assign accept     = (state == RUN) && valid_i;
    assign last_col   = (col == COL_LAST) && (row == ROW_LAST);

    assign ready_o    = (state == RUN);
    assign busy_o     = (state != IDLE);
    assign count_en_o = accept;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            drain_cnt    <= 1'b0;
            s1_valid     <= 1'b0;
            s1_last      <= 1'b0;
            s1_col       <= '0;
            s1_row       <= '0;
            win_valid_o  <= 1'b0;
            win_col_o    <= '0;
            win_row_o    <= '0;
            frame_done_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            // Tag pipeline advances every cycle; the gap-error branch below
            // overrides it to flush both stages.
            s1_valid     <= accept && (col >= 10'd4);
            s1_last      <= accept && last_col;
            s1_col       <= col - 10'd4;
            s1_row       <= row;
            win_valid_o  <= s1_valid;
            win_col_o    <= s1_col;
            win_row_o    <= s1_row;
            frame_done_o <= s1_valid && s1_last;

            case (state)
                IDLE: begin
                    if (start_i) begin
                        state <= RUN;
                        err_o <= 1'b0;
                        col   <= '0;
                        row   <= '0;
                    end
                end
                RUN: begin
                    if (valid_i) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                row       <= '0;
                                state     <= DRAIN;
                                drain_cnt <= 1'b0;
                            end else begin
                                row <= row + 10'd1;
                            end
                        end else begin
                            col <= col + 10'd1;
                        end
                    end else if (col != '0) begin
                        // Gap inside a row: abort the frame and drop pending tags.
                        err_o        <= 1'b1;
                        state        <= IDLE;
                        col          <= '0;
                        row          <= '0;
                        s1_valid     <= 1'b0;
                        s1_last      <= 1'b0;
                        win_valid_o  <= 1'b0;
                        frame_done_o <= 1'b0;
                    end
                end
                DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_window_buffer_5x5_ctrl.sv
// tb_window_buffer_5x5_ctrl
//   Directed bench for window_buffer_5x5_ctrl with COLS=8, ROWS=6 (two row
//   groups, four windows per row). Expected windows and their cycles are
//   derived from the cycles at which the bench itself presents columns.
module tb_window_buffer_5x5_ctrl;

    localparam int COLS = 8;
    localparam int ROWS = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i;
    logic       valid_i;
    logic       ready_o;
    logic       count_en_o;
    logic       win_valid_o;
    logic [9:0] win_col_o;
    logic [9:0] win_row_o;
    logic       busy_o;
    logic       frame_done_o;
    logic       err_o;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int last_acc = 0;

    int obs_col[$];
    int obs_row[$];
    int obs_cyc[$];
    int done_cyc[$];
    int exp_col[$];
    int exp_row[$];
    int exp_cyc[$];

    window_buffer_5x5_ctrl #(
        .COLS(COLS),
        .ROWS(ROWS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .count_en_o  (count_en_o),
        .win_valid_o (win_valid_o),
        .win_col_o   (win_col_o),
        .win_row_o   (win_row_o),
        .busy_o      (busy_o),
        .frame_done_o(frame_done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (win_valid_o) begin
            obs_col.push_back(int'(win_col_o));
            obs_row.push_back(int'(win_row_o));
            obs_cyc.push_back(cyc);
        end
        if (frame_done_o) done_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        obs_col.delete();
        obs_row.delete();
        obs_cyc.delete();
        done_cyc.delete();
        exp_col.delete();
        exp_row.delete();
        exp_cyc.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ready"}, int'(ready_o), 0);
        chk({tag, "_cen"}, int'(count_en_o), 0);
        chk({tag, "_wv"}, int'(win_valid_o), 0);
        chk({tag, "_wcol"}, int'(win_col_o), 0);
        chk({tag, "_wrow"}, int'(win_row_o), 0);
        chk({tag, "_busy"}, int'(busy_o), 0);
        chk({tag, "_done"}, int'(frame_done_o), 0);
        chk({tag, "_err"}, int'(err_o), 0);
    endtask

    task automatic compare_windows();
        int n;
        chk("nwin", obs_col.size(), exp_col.size());
        n = (obs_col.size() < exp_col.size()) ? obs_col.size() : exp_col.size();
        for (int i = 0; i < n; i++) begin
            chk("win_col", obs_col[i], exp_col[i]);
            chk("win_row", obs_row[i], exp_row[i]);
            chk("win_cyc", obs_cyc[i], exp_cyc[i]);
        end
        chk("ndone", done_cyc.size(), 1);
        if (done_cyc.size() > 0) chk("done_cyc", done_cyc[0], last_acc + 2);
    endtask

    // One full frame: gap = idle cycles between rows, valid_on_start drives
    // valid_i together with start_i, poke pulses start_i in RUN and DRAIN.
    task automatic run_frame(input int gap, input bit valid_on_start, input bit poke);
        clear_q();
        start_i = 1'b1;
        valid_i = valid_on_start;
        #1;
        chk("start_cen", int'(count_en_o), 0);
        step();
        start_i = 1'b0;
        chk("busy_s1", int'(busy_o), 1);
        chk("ready_s1", int'(ready_o), 1);
        chk("err_clr", int'(err_o), 0);
        for (int k = 0; k < COLS * (ROWS - 4); k++) begin
            if (k > 0 && (k % COLS) == 0) begin
                for (int g = 0; g < gap; g++) begin
                    valid_i = 1'b0;
                    step();
                end
            end
            valid_i = 1'b1;
            start_i = poke && (k == 3);
            #1;
            chk("run_cen", int'(count_en_o), 1);
            if ((k % COLS) >= 4) begin
                exp_col.push_back((k % COLS) - 4);
                exp_row.push_back(k / COLS);
                exp_cyc.push_back(cyc + 2);
            end
            last_acc = cyc;
            step();
            start_i = 1'b0;
        end
        // Cycle t+1: DRAIN
        valid_i = poke;
        start_i = poke;
        #1;
        chk("drain_ready", int'(ready_o), 0);
        chk("drain_cen", int'(count_en_o), 0);
        chk("drain_busy", int'(busy_o), 1);
        step();
        start_i = 1'b0;
        chk("drain2_busy", int'(busy_o), 1);
        step();
        // Cycle t+3: IDLE
        valid_i = 1'b0;
        chk("idle_busy", int'(busy_o), 0);
        chk("idle_ready", int'(ready_o), 0);
        chk("end_err", int'(err_o), 0);
        step();
        step();
        compare_windows();
    endtask

    initial begin
        rst_n   = 1'b1;
        start_i = 1'b0;
        valid_i = 1'b0;
        step();
        step();
        check_outputs_zero("rst");
        rst_n = 1'b0;
        step();

        // Back-to-back columns
        run_frame(0, 1'b0, 1'b0);

        // Three idle cycles between rows
        run_frame(3, 1'b0, 1'b0);

        // Mid-row gap at col=5 of row 0
        clear_q();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            valid_i = 1'b1;
            step();
        end
        valid_i = 1'b0;
        chk("pre_err", int'(err_o), 0);
        step();
        chk("err_set", int'(err_o), 1);
        chk("err_busy", int'(busy_o), 0);
        chk("err_ready", int'(ready_o), 0);
        chk("err_wv", int'(win_valid_o), 0);
        for (int i = 0; i < 4; i++) step();
        chk("err_nowin", obs_col.size(), 0);
        chk("err_sticky", int'(err_o), 1);
        run_frame(0, 1'b0, 1'b0);

        // valid_i together with start_i, valid held high
        run_frame(0, 1'b1, 1'b0);

        // Async reset mid-row at col=6, row 1
        clear_q();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int k = 0; k < COLS + 6; k++) begin
            valid_i = 1'b1;
            step();
        end
        chk("mid_busy", int'(busy_o), 1);
        #2;
        rst_n = 1'b1;
        #1;
        check_outputs_zero("arst");
        step();
        rst_n   = 1'b0;
        valid_i = 1'b0;
        step();
        run_frame(0, 1'b0, 1'b0);

        // start_i pulsed during RUN and DRAIN
        run_frame(0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
